// File: rtl/ps2_mouse_init_ctrl_pkg.sv
// rtl/ps2_mouse_init_ctrl_pkg.sv - PS/2 mouse command/response codes, FSM states and error codes
package ps2_mouse_init_ctrl_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] MOUSE_ID     = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_NEXT,
    ST_STREAM,
    ST_ERROR
  } state_t;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ACK_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_BAT_FAIL    = 3'd2;
  localparam logic [2:0] ERR_BAD_ID      = 3'd3;
  localparam logic [2:0] ERR_TX          = 3'd4;
  localparam logic [2:0] ERR_RESEND      = 3'd5;

  localparam int         TMR_W     = 26;
  localparam logic [1:0] LAST_STEP = 2'd3;

endpackage

// File: rtl/ps2_timeout_timer.sv
// rtl/ps2_timeout_timer.sv - response timeout counter with two selectable limits
module ps2_timeout_timer
  import ps2_mouse_init_ctrl_pkg::*;
#(
  parameter int ACK_LIMIT = 1_000_000,
  parameter int BAT_LIMIT = 40_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic limit_sel,
  output logic expired
);

  logic [TMR_W-1:0] count;
  logic [TMR_W-1:0] limit_m1;

  assign limit_m1 = limit_sel ? TMR_W'(BAT_LIMIT - 1) : TMR_W'(ACK_LIMIT - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Free-running wrap keeps the match to a single cycle; the owner leaves the wait state on it.
  assign expired = enable && (count == limit_m1);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// rtl/ps2_mouse_init_ctrl.sv - PS/2 mouse power-up sequencer into streaming mode
module ps2_mouse_init_ctrl
  import ps2_mouse_init_ctrl_pkg::*;
#(
  parameter logic [7:0] SAMPLE_RATE = 8'd100,
  parameter int         ACK_TIMEOUT = 1_000_000,
  parameter int         BAT_TIMEOUT = 40_000_000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic       iSTART,
  output logic [7:0] oTX_DATA,
  output logic       oTX_VALID,
  input  logic       iTX_READY,
  input  logic       iTX_DONE,
  input  logic       iTX_ERR,
  input  logic [7:0] iRX_DATA,
  input  logic       iRX_VALID,
  output logic       oBUSY,
  output logic       oSTREAM_EN,
  output logic       oERROR,
  output logic [2:0] oERR_CODE,
  output logic [1:0] oRETRY_CNT
);

  localparam logic [1:0] RETRY_MAX  = 2'(MAX_RETRY);
  localparam logic [2:0] RESEND_MAX = 3'(MAX_RETRY);

  state_t     state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [1:0] retry_q, retry_d;
  logic [2:0] resend_q, resend_d;
  logic [2:0] resend_inc;
  logic [2:0] err_code_q, err_code_d;
  logic       error_q, error_d;
  logic       stream_q, stream_d;
  logic       busy_q, busy_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       fail;
  logic [2:0] fail_code;
  logic       tmr_expired;

  function automatic logic [7:0] step_byte(input logic [1:0] s);
    case (s)
      2'd0:    step_byte = CMD_RESET;
      2'd1:    step_byte = CMD_SET_RATE;
      2'd2:    step_byte = SAMPLE_RATE;
      default: step_byte = CMD_ENABLE;
    endcase
  endfunction

  ps2_timeout_timer #(
    .ACK_LIMIT (ACK_TIMEOUT),
    .BAT_LIMIT (BAT_TIMEOUT)
  ) u_timer (
    .clk       (iCLK_50),
    .rst       (iRST),
    .clear     (state_d != state_q),
    .enable    (state_q == ST_WAIT_ACK || state_q == ST_WAIT_BAT || state_q == ST_WAIT_ID),
    .limit_sel (state_q == ST_WAIT_BAT),
    .expired   (tmr_expired)
  );

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      retry_q    <= '0;
      resend_q   <= '0;
      err_code_q <= ERR_NONE;
      error_q    <= 1'b0;
      stream_q   <= 1'b0;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      retry_q    <= retry_d;
      resend_q   <= resend_d;
      err_code_q <= err_code_d;
      error_q    <= error_d;
      stream_q   <= stream_d;
      busy_q     <= busy_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign resend_inc = resend_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    retry_d    = retry_q;
    resend_d   = resend_q;
    err_code_d = err_code_q;
    error_d    = error_q;
    stream_d   = stream_q;
    busy_d     = busy_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    case (state_q)
      ST_IDLE, ST_STREAM, ST_ERROR: begin
        if (iSTART) begin
          state_d    = ST_SEND;
          step_d     = '0;
          retry_d    = '0;
          resend_d   = '0;
          err_code_d = ERR_NONE;
          error_d    = 1'b0;
          stream_d   = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_valid_q && iTX_READY) state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (iTX_ERR) begin
          fail      = 1'b1;
          fail_code = ERR_TX;
        end else if (iTX_DONE) begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A byte arriving on the expiry cycle still counts as an answer.
        if (iRX_VALID) begin
          if (iRX_DATA == RSP_ACK) begin
            state_d = (step_q == 2'd0) ? ST_WAIT_BAT : ST_NEXT;
          end else if (iRX_DATA == RSP_RESEND) begin
            if (resend_inc <= RESEND_MAX) begin
              resend_d = resend_inc;
              state_d  = ST_SEND;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_RESEND;
            end
          end else begin
            fail      = 1'b1;
            fail_code = ERR_ACK_TIMEOUT;
          end
        end else if (tmr_expired) begin
          fail      = 1'b1;
          fail_code = ERR_ACK_TIMEOUT;
        end
      end
      ST_WAIT_BAT: begin
        if (iRX_VALID) begin
          if (iRX_DATA == RSP_BAT_OK) begin
            state_d = ST_WAIT_ID;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_BAT_FAIL;
          end
        end else if (tmr_expired) begin
          fail      = 1'b1;
          fail_code = ERR_BAT_FAIL;
        end
      end
      ST_WAIT_ID: begin
        if (iRX_VALID) begin
          if (iRX_DATA == MOUSE_ID) begin
            state_d = ST_NEXT;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_BAD_ID;
          end
        end else if (tmr_expired) begin
          fail      = 1'b1;
          fail_code = ERR_ACK_TIMEOUT;
        end
      end
      ST_NEXT: begin
        resend_d = '0;
        if (step_q == LAST_STEP) begin
          state_d  = ST_STREAM;
          stream_d = 1'b1;
          busy_d   = 1'b0;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      err_code_d = fail_code;
      if (retry_q < RETRY_MAX) begin
        retry_d  = retry_q + 2'd1;
        step_d   = '0;
        resend_d = '0;
        state_d  = ST_SEND;
      end else begin
        state_d = ST_ERROR;
        error_d = 1'b1;
        busy_d  = 1'b0;
      end
    end

    tx_valid_d = (state_d == ST_SEND);
    tx_data_d  = (state_d == ST_SEND) ? step_byte(step_d) : tx_data_q;
  end

  // Valid is masked by reset combinationally so a pending byte is withdrawn at once.
  assign oTX_VALID  = tx_valid_q & ~iRST;
  assign oTX_DATA   = tx_data_q;
  assign oBUSY      = busy_q;
  assign oSTREAM_EN = stream_q;
  assign oERROR     = error_q;
  assign oERR_CODE  = err_code_q;
  assign oRETRY_CNT = retry_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// tb/tb_ps2_mouse_init_ctrl.sv - directed self-checking bench for ps2_mouse_init_ctrl
module tb_ps2_mouse_init_ctrl;

  localparam int ACK_T = 20;
  localparam int BAT_T = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       stream_en;
  logic       error;
  logic [2:0] err_code;
  logic [1:0] retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int gap;

  ps2_mouse_init_ctrl #(
    .SAMPLE_RATE (8'd100),
    .ACK_TIMEOUT (ACK_T),
    .BAT_TIMEOUT (BAT_T),
    .MAX_RETRY   (3)
  ) dut (
    .iCLK_50    (clk),
    .iRST       (rst),
    .iSTART     (start),
    .oTX_DATA   (tx_data),
    .oTX_VALID  (tx_valid),
    .iTX_READY  (tx_ready),
    .iTX_DONE   (tx_done),
    .iTX_ERR    (tx_err),
    .iRX_DATA   (rx_data),
    .iRX_VALID  (rx_valid),
    .oBUSY      (busy),
    .oSTREAM_EN (stream_en),
    .oERROR     (error),
    .oERR_CODE  (err_code),
    .oRETRY_CNT (retry_cnt)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Polls for a presented byte; returns the number of cycles waited.
  task automatic wait_tx(input string tag, input logic [7:0] exp, output int cycles);
    cycles = 0;
    while (!tx_valid && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_data"}, 32'(tx_data), 32'(exp));
  endtask

  task automatic finish_tx(input logic err);
    @(negedge clk);
    if (err) tx_err = 1'b1;
    else tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    tx_err  = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic step(input string tag, input logic [7:0] cmd, input logic [7:0] reply);
    int c;
    wait_tx(tag, cmd, c);
    finish_tx(1'b0);
    rx(reply);
  endtask

  task automatic reset_step(input string tag);
    step(tag, 8'hFF, 8'hFA);
    rx(8'hAA);
    rx(8'h00);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b1;
    tx_done  = 1'b0;
    tx_err   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stream", 32'(stream_en), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal init; the F3 ACK lands exactly on the timeout cycle.
    rx(8'hAA);
    check("idle_rx_ignored", 32'(busy), 32'd0);
    pulse_start();
    check("nom_busy", 32'(busy), 32'd1);
    reset_step("nom_ff");
    wait_tx("nom_f3", 8'hF3, gap);
    finish_tx(1'b0);
    repeat (ACK_T - 1) @(negedge clk);
    rx(8'hFA);
    step("nom_64", 8'h64, 8'hFA);
    step("nom_f4", 8'hF4, 8'hFA);
    @(negedge clk);
    check("nom_stream", 32'(stream_en), 32'd1);
    check("nom_busy_end", 32'(busy), 32'd0);
    check("nom_retry", 32'(retry_cnt), 32'd0);
    check("nom_err_code", 32'(err_code), 32'd0);
    rx(8'hFA);
    check("stream_rx_ignored", 32'(stream_en), 32'd1);

    // Resend twice on F3; a start while busy is ignored.
    pulse_start();
    step("rs_ff", 8'hFF, 8'hFA);
    pulse_start();
    rx(8'hAA);
    rx(8'h00);
    step("rs_f3_1", 8'hF3, 8'hFE);
    step("rs_f3_2", 8'hF3, 8'hFE);
    step("rs_f3_3", 8'hF3, 8'hFA);
    step("rs_64", 8'h64, 8'hFA);
    step("rs_f4", 8'hF4, 8'hFA);
    @(negedge clk);
    check("rs_stream", 32'(stream_en), 32'd1);
    check("rs_err_code", 32'(err_code), 32'd0);
    check("rs_retry", 32'(retry_cnt), 32'd0);

    // BAT failure, then a clean second attempt.
    pulse_start();
    step("bat_ff_1", 8'hFF, 8'hFA);
    rx(8'hFC);
    reset_step("bat_ff_2");
    step("bat_f3", 8'hF3, 8'hFA);
    step("bat_64", 8'h64, 8'hFA);
    step("bat_f4", 8'hF4, 8'hFA);
    @(negedge clk);
    check("bat_stream", 32'(stream_en), 32'd1);
    check("bat_retry", 32'(retry_cnt), 32'd1);
    check("bat_err_code", 32'(err_code), 32'd2);

    // Transmit error on F4 restarts from FF.
    pulse_start();
    reset_step("txe_ff_1");
    step("txe_f3", 8'hF3, 8'hFA);
    step("txe_64", 8'h64, 8'hFA);
    wait_tx("txe_f4", 8'hF4, gap);
    finish_tx(1'b1);
    check("txe_err_code", 32'(err_code), 32'd4);
    check("txe_retry", 32'(retry_cnt), 32'd1);
    reset_step("txe_ff_2");
    step("txe_f3b", 8'hF3, 8'hFA);
    step("txe_64b", 8'h64, 8'hFA);
    step("txe_f4b", 8'hF4, 8'hFA);
    @(negedge clk);
    check("txe_stream", 32'(stream_en), 32'd1);

    // Silent device: four FF attempts ACK_T cycles apart, then fatal error.
    pulse_start();
    wait_tx("to_ff_0", 8'hFF, gap);
    finish_tx(1'b0);
    for (int i = 1; i < 4; i++) begin
      wait_tx($sformatf("to_ff_%0d", i), 8'hFF, gap);
      check($sformatf("to_gap_%0d", i), 32'(gap), 32'(ACK_T));
      finish_tx(1'b0);
    end
    repeat (ACK_T + 1) @(negedge clk);
    check("to_error", 32'(error), 32'd1);
    check("to_err_code", 32'(err_code), 32'd1);
    check("to_retry", 32'(retry_cnt), 32'd3);
    check("to_busy", 32'(busy), 32'd0);
    check("to_tx_valid", 32'(tx_valid), 32'd0);
    pulse_start();
    check("to_restart_error", 32'(error), 32'd0);
    check("to_restart_busy", 32'(busy), 32'd1);
    check("to_restart_code", 32'(err_code), 32'd0);

    // Reset while waiting for BAT; a late AA is ignored.
    step("mr_ff", 8'hFF, 8'hFA);
    rst = 1'b1;
    @(negedge clk);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_tx_valid", 32'(tx_valid), 32'd0);
    check("mr_tx_data", 32'(tx_data), 32'd0);
    check("mr_retry", 32'(retry_cnt), 32'd0);
    rst = 1'b0;
    rx(8'hAA);
    repeat (3) @(negedge clk);
    check("mr_post_busy", 32'(busy), 32'd0);
    check("mr_post_valid", 32'(tx_valid), 32'd0);
    check("mr_post_stream", 32'(stream_en), 32'd0);
    check("mr_post_error", 32'(error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
